// File: rtl/sint_eq_arbiter.sv
// ---------------------------------------------------------------------------
// sint_eq_arbiter
//
// Purpose:
//   Shares a single WIDTH-bit signed equality comparator between NREQ
//   requesters. One request is granted per cycle in round-robin order. The
//   comparison result is registered into a one-entry output stage and is
//   returned on a valid/ready response channel, tagged with the id of the
//   requester that produced it. A saturating counter records how many
//   accepted responses reported equality.
//
// Ports:
//   CLK          in   rising-edge clock
//   ASYNCRESETN  in   asynchronous active-low reset
//   req_valid    in   [NREQ]        per-requester request valid
//   req_ready    out  [NREQ]        per-requester accept (one-hot or zero)
//   req_a        in   [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b        in   [NREQ*WIDTH]  operand B, same packing as req_a
//   rsp_valid    out               response valid
//   rsp_ready    in                response consumer ready
//   rsp_eq       out               A == B for the held response
//   rsp_id       out  [IDW]        requester index of the held response
//   clr_count    in                synchronous clear of match_count
//   match_count  out  [CNTW]       accepted equal responses, saturating
// ---------------------------------------------------------------------------
module sint_eq_arbiter #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic                    CLK,
    input  logic                    ASYNCRESETN,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_eq,
    output logic [IDW-1:0]          rsp_id,
    input  logic                    clr_count,
    output logic [CNTW-1:0]         match_count
);

    // Registered state
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_eq_q,    rsp_eq_d;
    logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;
    logic [CNTW-1:0]  cnt_q,       cnt_d;

    // Arbitration and datapath signals
    logic             slot_free;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   scan_idx;
    logic             transfer;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cmp_eq;
    logic             rsp_accept;

    // The output register is a single pipeline stage: it can take a new
    // result in the same cycle the current one is consumed.
    assign slot_free = !rsp_valid_q || rsp_ready;

    // Round-robin scan starting at ptr_q. Only req_valid is looked at, so
    // the grant never depends on operand values.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            scan_idx = IDW'((32'(ptr_q) + off) % NREQ);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // ASYNCRESETN gates the grant so req_ready is zero for the whole reset
    // assertion, not just after the registers clear.
    assign transfer  = gnt_found && slot_free && ASYNCRESETN;
    assign req_ready = transfer ? (NREQ'(1) << gnt_idx) : '0;

    // Operand mux in front of the single shared comparator.
    assign op_a = req_a[32'(gnt_idx)*WIDTH +: WIDTH];
    assign op_b = req_b[32'(gnt_idx)*WIDTH +: WIDTH];

    coreir_eq #(
        .width(WIDTH)
    ) u_eq (
        .in0 (op_a),
        .in1 (op_b),
        .out (cmp_eq)
    );

    assign rsp_accept = rsp_valid_q && rsp_ready;

    // Next-state logic
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;

        if (transfer) begin
            rsp_valid_d = 1'b1;
            rsp_eq_d    = cmp_eq;
            rsp_id_d    = gnt_idx;
            ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        // Clear has priority over a simultaneous increment.
        if (clr_count) begin
            cnt_d = '0;
        end else if (rsp_accept && rsp_eq_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            rsp_valid_q <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_eq      = rsp_eq_q;
    assign rsp_id      = rsp_id_q;
    assign match_count = cnt_q;

    // Requester protocol: a pending request keeps valid and operands stable
    // until it is accepted.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_proto
        assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            (req_valid[gi] && !req_ready[gi]) |=>
                (req_valid[gi] &&
                 $stable(req_a[gi*WIDTH +: WIDTH]) &&
                 $stable(req_b[gi*WIDTH +: WIDTH])));
    end

    assert property (@(posedge CLK) $onehot0(req_ready));

endmodule

// ---------------------------------------------------------------------------
// coreir_eq
//
// Purpose:
//   Plain bitwise equality comparator; signedness does not affect equality.
//
// Ports:
//   in0, in1  in   [width]  operands
//   out       out           1 when in0 == in1
// ---------------------------------------------------------------------------
module coreir_eq #(
    parameter int unsigned width = 7
) (
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    output logic             out
);

    assign out = (in0 == in1);

endmodule

// File: tb/tb_sint_eq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sint_eq_arbiter
//
// Self-checking bench for sint_eq_arbiter. A behavioural model (pointer,
// pending response and counter kept as plain integers) is compared against
// the DUT on every falling clock edge. Directed sequences pin the model to
// hand-computed values; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_sint_eq_arbiter;

    localparam int unsigned WIDTH = 7;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned CNTW  = 4;
    localparam int          CMAX  = (1 << CNTW) - 1;

    logic                  CLK         = 1'b0;
    logic                  ASYNCRESETN = 1'b0;
    logic [NREQ-1:0]       req_valid   = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a       = '0;
    logic [NREQ*WIDTH-1:0] req_b       = '0;
    logic                  rsp_valid;
    logic                  rsp_ready   = 1'b0;
    logic                  rsp_eq;
    logic [IDW-1:0]        rsp_id;
    logic                  clr_count   = 1'b0;
    logic [CNTW-1:0]       match_count;

    sint_eq_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW),
        .CNTW  (CNTW)
    ) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_eq      (rsp_eq),
        .rsp_id      (rsp_id),
        .clr_count   (clr_count),
        .match_count (match_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Requests accepted at the most recent clock edge (for protocol-correct refill).
    logic [NREQ-1:0] acc = '0;

    // Behavioural model state
    int m_ptr   = 0;
    int m_id    = 0;
    int m_cnt   = 0;
    bit m_valid = 1'b0;
    bit m_eq    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Winner the rules call for given the current inputs and model state; -1 if none.
    function automatic int m_winner();
        if (m_valid && !rsp_ready) return -1;
        for (int k = 0; k < int'(NREQ); k++) begin
            int i;
            i = (m_ptr + k) % int'(NREQ);
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // Compare DUT against the model, then advance the model to the next edge.
    always @(negedge CLK) begin : model
        int              w;
        logic [NREQ-1:0] exp_ready;
        if (!ASYNCRESETN) begin
            m_valid = 1'b0;
            m_eq    = 1'b0;
            m_id    = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_match_count", 32'(match_count), 0);
        end else begin
            w = m_winner();
            exp_ready = '0;
            if (w >= 0) exp_ready[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("match_count", 32'(match_count), 32'(m_cnt));
            if (m_valid) begin
                chk("rsp_eq", 32'(rsp_eq), 32'(m_eq));
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
            end
            if (clr_count) m_cnt = 0;
            else if (m_valid && rsp_ready && m_eq && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (w >= 0) begin
                m_valid = 1'b1;
                m_eq    = ($signed(req_a[w*WIDTH +: WIDTH]) == $signed(req_b[w*WIDTH +: WIDTH]));
                m_id    = w;
                m_ptr   = (w + 1) % int'(NREQ);
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_valid[i] = 1'b1;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic rand_ops(input int i);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a = WIDTH'($urandom);
        b = ($urandom_range(0, 1) != 0) ? a : WIDTH'($urandom);
        set_req(i, a, b);
    endtask

    // Refill free requesters per 'want'; pending ones are held untouched.
    task automatic drive_next(input logic [NREQ-1:0] want);
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!(req_valid[i] && !acc[i])) begin
                if (want[i]) rand_ops(i);
                else req_valid[i] = 1'b0;
            end
        end
    endtask

    // One clock: record the handshake before the edge, return 1 unit after it.
    task automatic cycle();
        @(negedge CLK);
        acc = req_ready & req_valid;
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        drive_next('0);
        while (req_valid != '0 && n < 40) begin
            cycle();
            drive_next('0);
            n++;
        end
        checks++;
        if (req_valid != '0) begin
            errors++;
            $display("FAIL drain_timeout: pending %b, required 0", req_valid);
        end
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        // Power-on reset
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #1 ASYNCRESETN = 1'b1;

        // Round robin with all four requesting: ids 0,1,2,3,0,1
        rsp_ready = 1'b1;
        drive_next(4'b1111);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_all_id", 32'(rsp_id), 32'(k % 4));
            if (k < 5) drive_next(4'b1111);
        end
        drain();                                   // grants 2,3,0 -> ptr 1

        // Backpressure: response from req1 held for 5 cycles
        set_req(0, 7'h01, 7'h02);
        set_req(1, 7'h11, 7'h11);
        set_req(2, 7'h22, 7'h23);
        set_req(3, 7'h05, 7'h05);
        cycle();
        chk("bp_first_id", 32'(rsp_id), 1);
        chk("bp_first_eq", 32'(rsp_eq), 1);
        req_valid[1] = 1'b0;
        rsp_ready    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_req_ready", 32'(req_ready), 0);
            cycle();
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_id", 32'(rsp_id), 1);
            chk("bp_eq", 32'(rsp_eq), 1);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'(4'b0100));
        cycle();
        chk("bp_next_id", 32'(rsp_id), 2);
        chk("bp_next_eq", 32'(rsp_eq), 0);
        drain();                                   // grants 3,0 -> ptr 1

        // Asynchronous reset with a response pending
        rsp_ready = 1'b0;
        set_req(0, 7'h03, 7'h03);
        cycle();
        chk("pre_rst_valid", 32'(rsp_valid), 1);
        req_valid[0] = 1'b0;
        #2 ASYNCRESETN = 1'b0;
        rsp_ready = 1'b1;
        set_req(3, 7'h0A, 7'h0B);
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 0);
        chk("async_rst_ready", 32'(req_ready), 0);
        chk("async_rst_count", 32'(match_count), 0);
        chk("async_rst_id", 32'(rsp_id), 0);
        chk("async_rst_eq", 32'(rsp_eq), 0);
        @(posedge CLK);
        #1 ASYNCRESETN = 1'b1;
        #1 chk("post_rst_ready", 32'(req_ready), 32'(4'b1000));
        cycle();
        chk("post_rst_id", 32'(rsp_id), 3);
        drain();                                   // ptr 0

        // Only requesters 1 and 3: ids 1,3,1,3
        drive_next(4'b1010);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_pair_id", 32'(rsp_id), (k % 2 == 0) ? 1 : 3);
            if (k < 3) drive_next(4'b1010);
        end
        drain();

        // Clear counter, then single requests on requester 2
        clr_count = 1'b1;
        cycle();
        clr_count = 1'b0;
        chk("clr_count", 32'(match_count), 0);
        set_req(2, 7'h79, 7'h79);
        #1 chk("single_ready", 32'(req_ready), 32'(4'b0100));
        cycle();
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_eq", 32'(rsp_eq), 1);
        chk("single_id", 32'(rsp_id), 2);
        chk("single_cnt0", 32'(match_count), 0);
        req_valid[2] = 1'b0;
        cycle();
        chk("single_cnt1", 32'(match_count), 1);
        chk("single_idle", 32'(rsp_valid), 0);
        set_req(2, 7'h79, 7'h07);
        #1 chk("single_ne_ready", 32'(req_ready), 32'(4'b0100));
        cycle();
        chk("single_ne_eq", 32'(rsp_eq), 0);
        chk("single_ne_id", 32'(rsp_id), 2);
        req_valid[2] = 1'b0;
        cycle();
        chk("single_ne_cnt", 32'(match_count), 1);

        // Signed boundary
        set_req(0, 7'h40, 7'h3F);
        cycle();
        chk("bnd_ne_eq", 32'(rsp_eq), 0);
        chk("bnd_ne_id", 32'(rsp_id), 0);
        set_req(0, 7'h40, 7'h40);
        cycle();
        chk("bnd_eq_eq", 32'(rsp_eq), 1);
        req_valid[0] = 1'b0;
        cycle();
        chk("bnd_cnt", 32'(match_count), 2);

        // Saturation: 17 more equal results from 2 -> stops at 15
        for (int n = 0; n < 17; n++) begin
            set_req(0, WIDTH'(n), WIDTH'(n));
            cycle();
        end
        req_valid[0] = 1'b0;
        cycle();
        chk("sat_cnt", 32'(match_count), 15);

        // Clear together with an accepted equal response
        set_req(1, 7'h09, 7'h09);
        cycle();
        chk("clr_race_eq", 32'(rsp_eq), 1);
        req_valid[1] = 1'b0;
        clr_count = 1'b1;
        cycle();
        clr_count = 1'b0;
        chk("clr_race_cnt", 32'(match_count), 0);
        chk("clr_race_valid", 32'(rsp_valid), 0);

        // Randomized traffic with occasional clear and one mid-run reset
        for (int c = 0; c < 1500; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            clr_count = ($urandom_range(0, 63) == 0);
            drive_next(NREQ'($urandom));
            cycle();
            if (c == 700) begin
                #2 ASYNCRESETN = 1'b0;
                req_valid = '0;
                acc = '0;
                @(posedge CLK);
                #1 ASYNCRESETN = 1'b1;
            end
        end
        clr_count = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sint_eq_arbiter.md
Name: sint_eq_arbiter

Overview:
- Shares one WIDTH-bit signed equality comparator (coreir_eq instance) among NREQ requesters.
- Arbitration is round-robin, one grant per cycle.
- Each result is registered and returned on a valid/ready response channel tagged with the requester id.
- A saturating match counter tracks accepted equal results for software/debug visibility.

Parameters:
- WIDTH, 7, operand width in bits (two's-complement SInt)
- NREQ, 4, number of requesters (2..8)
- IDW, 2, id tag width; must equal ceil(log2(NREQ))
- CNTW, 16, width of the match counter

Ports:
- CLK  input  1  clock, rising edge
- ASYNCRESETN  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit set per cycle
- req_a  input  NREQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_eq  output  1  1 when A == B for the response held
- rsp_id  output  IDW  index of the requester that produced the response
- clr_count  input  1  synchronous clear of match_count
- match_count  output  CNTW  number of accepted responses with rsp_eq=1, saturating

Behaviour:
- Reset (ASYNCRESETN=0, takes effect immediately regardless of CLK):
  - rsp_valid=0, rsp_eq=0, rsp_id=0, match_count=0, rr pointer=0.
  - req_ready is all zeros while reset is asserted.
- Slot free: slot_free = !rsp_valid | rsp_ready. The output register is a one-entry pipeline stage, so it accepts a new request in the same cycle the old response is taken.
- Grant (combinational):
  - Scan i = ptr, ptr+1, ... mod NREQ.
  - The first i with req_valid[i]=1 wins, and only if slot_free=1.
  - req_ready[g]=1 for the winner only. All bits are 0 if there is no winner or slot_free=0.
  - req_ready must not depend on the other requesters' operand values.
- Transfer: a request transfers when req_valid[g] & req_ready[g]. On that clock edge:
  - rsp_valid <= 1
  - rsp_eq <= (req_a[g] == req_b[g]), evaluated through the single shared comparator; the operand mux selects by g
  - rsp_id <= g
  - ptr <= (g+1) mod NREQ
- Latency: exactly one cycle from request transfer to rsp_valid.
- No transfer and rsp_ready=1: rsp_valid <= 0. rsp_eq and rsp_id hold their values (don't-care while invalid).
- Backpressure: while rsp_valid=1 and rsp_ready=0:
  - rsp_eq and rsp_id are stable.
  - req_ready is all zeros.
  - ptr holds.
- ptr advances only on a transfer. An idle cycle never moves it.
- Equality is bitwise over WIDTH bits. Signedness does not affect eq; -1 (7'h7F) equals only 7'h7F.
- match_count:
  - On rsp_valid & rsp_ready & rsp_eq: +1, saturating at 2^CNTW-1 (no wrap).
  - clr_count=1 forces 0 on that edge. Clear wins over a simultaneous increment.
- The comparator is the only WIDTH-bit compare resource; no per-requester comparators.
- Requester protocol (checked by assertions, not handled): once req_valid[i]=1 it stays asserted and the operands stay stable until accepted.
- Reset mid-operation: any pending response is dropped (rsp_valid=0 immediately) and ptr returns to 0. After release, the first grant goes to the lowest valid index.

Test Plan:
- Reset values: assert ASYNCRESETN=0 mid-cycle with rsp_valid=1 -> rsp_valid, match_count, req_ready drop to 0 without a clock edge. After release, only req_valid=4'b1000 -> req_ready=4'b1000.
- Single request, NREQ=4: only req_valid[2]=1, A=7'h79 (-7), B=7'h79, rsp_ready=1 -> req_ready=4'b0100 that cycle. Next cycle: rsp_valid=1, rsp_eq=1, rsp_id=2, then match_count=1. Repeat with B=7'h07 -> rsp_eq=0, match_count unchanged.
- Round-robin fairness: all four req_valid held high, rsp_ready=1 -> one grant per cycle, rsp_id sequence 0,1,2,3,0,1. With only requesters 1 and 3 valid -> 1,3,1,3.
- Backpressure: rsp_ready=0 for 5 cycles with a response pending -> rsp_eq and rsp_id stable, req_ready=0, ptr frozen. When rsp_ready rises, the next grant is issued in that same cycle (back-to-back, no bubble).
- Counter saturation/clear, CNTW=4: 17 accepted equal responses -> match_count stops at 15. Assert clr_count in the same cycle as an accepted equal response -> match_count=0.
- Signed boundary: A=7'h40 (-64), B=7'h3F (+63) -> rsp_eq=0. A=B=7'h40 -> rsp_eq=1.
